seg7_mux_counter: RTL and testbench
===================================

Name: seg7_mux_counter

Overview:
- Parametrised multi-digit BCD counter driving a time-multiplexed common-cathode/anode 7-segment display.
- Next-generation replacement for the single-digit, fixed-modulus display counter in the top-level tile.
- Adds configurable digit count and prescaler, up/down counting, enable, synchronous clear/load, carry output, digit scanning, leading-zero blanking and selectable output polarity.
- Sits between the top-level pins (ui_in controls, uo_out/uio_out display) and the clock/reset.

Parameters:
- TICK_DIV, 10000000: clk cycles per count step; legal range >= 2.
- DIGITS, 4: number of BCD digits; legal range 1..8.
- SCAN_DIV, 1000: clk cycles per digit-scan step; legal range >= 1.
- BLANK_LZ, 1: 1 = blank leading zero digits.
- COMMON_ANODE, 0: 1 = invert seg, dp and digit_sel (active-low drive).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  count enable; when low, prescaler holds.
- up_dn  input  1  1 = count up, 0 = count down.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous load of load_value.
- load_value  input  4*DIGITS  BCD value; digit 0 in bits [3:0].
- count  output  4*DIGITS  current BCD count, registered.
- tick  output  1  one-cycle pulse on each count step, registered.
- carry_out  output  1  one-cycle pulse when a step wraps, registered.
- seg  output  7  segments, bit0 = a … bit6 = g.
- dp  output  1  decimal point.
- digit_sel  output  DIGITS  one-hot digit enable.

Behaviour:
- Reset (rst_n = 0 at a clk edge) clears:
  - count = 0, prescaler = 0, tick = 0, carry_out = 0.
  - Scan index = 0, scan counter = 0.
  - Outputs then show digit 0 as "0" with digit_sel = one-hot bit 0 (polarity applied).
- Control priority per edge: rst_n > clear > load > counting.
- clear = 1:
  - count <= 0, prescaler <= 0, tick <= 0, carry_out <= 0.
  - Ignores en and load.
- load = 1 (clear = 0):
  - count <= load_value with each nibble > 9 saturated to 9.
  - prescaler <= 0, tick <= 0, carry_out <= 0.
- Prescaler (en = 1, no clear/load):
  - If prescaler == TICK_DIV-1: prescaler <= 0, count steps, tick <= 1.
  - Otherwise: prescaler <= prescaler+1, tick <= 0.
  - en = 0: prescaler and count hold, tick <= 0, carry_out <= 0.
- Timing: from reset with en held 1, the first count change and tick are visible after the TICK_DIV-th rising edge. tick is high in the same cycle the new count is visible.
- Count step, up (up_dn = 1):
  - BCD increment with ripple; digit 9 -> 0 carries into the next digit.
  - All-9s -> all-0s sets carry_out <= 1 for that cycle. Otherwise carry_out <= 0.
- Count step, down (up_dn = 0):
  - BCD decrement with borrow; digit 0 -> 9 borrows.
  - All-0s -> all-9s sets carry_out <= 1.
- up_dn is sampled only on the step edge; changing it mid-period has no other effect.
- Scan:
  - Free-running, independent of en, clear and load; only reset affects it.
  - Scan counter counts 0..SCAN_DIV-1. On wrap, scan index advances idx+1 mod DIGITS.
  - With DIGITS = 1 the index stays 0.
- Display decode (combinational from count and scan index):
  - seg/digit_sel change in the same cycle as the index.
  - digit_sel = one-hot(idx).
  - seg codes (active-high, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles > 9 never occur.
  - Blanking (BLANK_LZ = 1): digit idx > 0 shows seg = 00 when it and every higher digit are 0. Digit 0 is never blanked.
  - dp = 1 only when idx == 0 and en == 0 (paused indicator).
- COMMON_ANODE = 1 inverts seg, dp and digit_sel bitwise after decode/blanking. Reset values follow that inversion.
- Reset mid-period discards the prescaler phase; the next step occurs TICK_DIV edges after reset release.

Test Plan:
(Parameters TICK_DIV=4, DIGITS=2, SCAN_DIV=2, BLANK_LZ=1, COMMON_ANODE=0 unless noted.)
- Reset, then en=1 for 8 edges -> count 00 → 01 after edge 4, 02 after edge 8; tick high exactly in those 2 cycles; carry_out stays 0.
- load_value=0x99 with load=1 for 1 edge, then up_dn=1, en=1 for 4 edges -> count 99 then 00; tick=1 and carry_out=1 in the same cycle.
- count=00, up_dn=0, en=1 for 4 edges -> count 99, carry_out=1. Then load_value=0xA3 -> count 93 (nibble saturated).
- Load 0x05, observe 4 edges of scan -> idx 0: digit_sel=01, seg=6D; idx 1: digit_sel=10, seg=00 (blanked). Load 0x50 -> idx 1: seg=6D; idx 0: seg=3F.
- en=0, clear and load asserted together with load_value=0x42 -> count 00, prescaler 0, dp=1 when idx=0. Then clear=0, load=1 -> count 42.
- COMMON_ANODE=1: after reset -> seg=0x40 (inverted 3F), digit_sel=2'b10, dp=1 while en=1. Assert rst_n=0 mid-count -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter
// Multi-digit BCD up/down counter with a prescaled count step, driving a
// time-multiplexed 7-segment display (one digit lit at a time).
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   en          count enable (prescaler holds when low)
//   up_dn       1 = count up, 0 = count down (sampled on the step edge)
//   clear       synchronous clear of count and prescaler
//   load        synchronous load of load_value (nibbles > 9 saturate to 9)
//   load_value  BCD load value, digit 0 in bits [3:0]
//   count       registered BCD count
//   tick        one-cycle pulse on each count step
//   carry_out   one-cycle pulse when a step wraps (all-9s <-> all-0s)
//   seg         segments a..g in bits 0..6
//   dp          decimal point, lit on digit 0 while paused
//   digit_sel   one-hot digit enable
module seg7_mux_counter #(
    parameter int TICK_DIV     = 10000000,
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_LZ     = 1,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry_out,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int CW     = 4 * DIGITS;
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]     count_reg;
    logic [PRE_W-1:0]  prescaler_reg;
    logic              tick_reg;
    logic              carry_reg;
    logic [SCAN_W-1:0] scan_cnt_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic [CW-1:0]     load_sat;
    logic [3:0]        digit [DIGITS];
    // upper_zero[i] = digit i and every digit above it are zero
    logic              upper_zero [DIGITS+1];

    assign upper_zero[DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign load_sat[gi*4 +: 4] = (load_value[gi*4 +: 4] > 4'd9) ? 4'd9
                                                                          : load_value[gi*4 +: 4];
            assign digit[gi]      = count_reg[gi*4 +: 4];
            assign upper_zero[gi] = (digit[gi] == 4'd0) && upper_zero[gi+1];
        end
    endgenerate

    // Ripple BCD increment/decrement; the carry/borrow left over after the
    // top digit means the whole count wrapped.
    logic [CW-1:0] count_inc;
    logic [CW-1:0] count_dec;
    logic          inc_c;
    logic          dec_b;

    always_comb begin
        count_inc = count_reg;
        count_dec = count_reg;
        inc_c     = 1'b1;
        dec_b     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_c) begin
                if (count_reg[i*4 +: 4] == 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count_reg[i*4 +: 4] + 4'd1;
                    inc_c = 1'b0;
                end
            end
            if (dec_b) begin
                if (count_reg[i*4 +: 4] == 4'd0) begin
                    count_dec[i*4 +: 4] = 4'd9;
                end else begin
                    count_dec[i*4 +: 4] = count_reg[i*4 +: 4] - 4'd1;
                    dec_b = 1'b0;
                end
            end
        end
    end

    logic [CW-1:0] step_count;
    logic          step_wrap;

    assign step_count = up_dn ? count_inc : count_dec;
    assign step_wrap  = up_dn ? inc_c : dec_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg     <= '0;
            prescaler_reg <= '0;
            tick_reg      <= 1'b0;
            carry_reg     <= 1'b0;
        end else if (clear) begin
            count_reg     <= '0;
            prescaler_reg <= '0;
            tick_reg      <= 1'b0;
            carry_reg     <= 1'b0;
        end else if (load) begin
            count_reg     <= load_sat;
            prescaler_reg <= '0;
            tick_reg      <= 1'b0;
            carry_reg     <= 1'b0;
        end else if (en) begin
            if (prescaler_reg == PRE_W'(TICK_DIV - 1)) begin
                prescaler_reg <= '0;
                count_reg     <= step_count;
                tick_reg      <= 1'b1;
                carry_reg     <= step_wrap;
            end else begin
                prescaler_reg <= prescaler_reg + 1'b1;
                tick_reg      <= 1'b0;
                carry_reg     <= 1'b0;
            end
        end else begin
            tick_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end
    end

    // Display scan is free-running: only reset touches it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
        end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            idx_reg      <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    // Display decode (active-high before polarity is applied)
    logic [3:0]        cur_digit;
    logic              blank;
    logic [6:0]        seg_raw;
    logic              dp_raw;
    logic [DIGITS-1:0] sel_raw;

    assign cur_digit = digit[idx_reg];
    assign blank     = (BLANK_LZ != 0) && (idx_reg != '0) && upper_zero[idx_reg];
    assign dp_raw    = (idx_reg == '0) && !en;
    assign sel_raw   = DIGITS'(1) << idx_reg;

    always_comb begin
        seg_raw = 7'h00;
        if (!blank) begin
            case (cur_digit)
                4'd0:    seg_raw = 7'h3F;
                4'd1:    seg_raw = 7'h06;
                4'd2:    seg_raw = 7'h5B;
                4'd3:    seg_raw = 7'h4F;
                4'd4:    seg_raw = 7'h66;
                4'd5:    seg_raw = 7'h6D;
                4'd6:    seg_raw = 7'h7D;
                4'd7:    seg_raw = 7'h07;
                4'd8:    seg_raw = 7'h7F;
                4'd9:    seg_raw = 7'h6F;
                default: seg_raw = 7'h00;
            endcase
        end
    end

    assign count     = count_reg;
    assign tick      = tick_reg;
    assign carry_out = carry_reg;
    assign seg       = (COMMON_ANODE != 0) ? ~seg_raw : seg_raw;
    assign dp        = (COMMON_ANODE != 0) ? ~dp_raw  : dp_raw;
    assign digit_sel = (COMMON_ANODE != 0) ? ~sel_raw : sel_raw;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Testbench for seg7_mux_counter: TICK_DIV=4, DIGITS=2, SCAN_DIV=2.
// Two instances share all inputs: one common-cathode, one common-anode.
module tb_seg7_mux_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [7:0] load_value;

    logic [7:0] count,     count_ca;
    logic       tick,      tick_ca;
    logic       carry_out, carry_ca;
    logic [6:0] seg,       seg_ca;
    logic       dp,        dp_ca;
    logic [1:0] digit_sel, sel_ca;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_mux_counter #(
        .TICK_DIV(4), .DIGITS(2), .SCAN_DIV(2), .BLANK_LZ(1), .COMMON_ANODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count), .tick(tick),
        .carry_out(carry_out), .seg(seg), .dp(dp), .digit_sel(digit_sel)
    );

    seg7_mux_counter #(
        .TICK_DIV(4), .DIGITS(2), .SCAN_DIV(2), .BLANK_LZ(1), .COMMON_ANODE(1)
    ) dut_ca (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_value(load_value), .count(count_ca), .tick(tick_ca),
        .carry_out(carry_ca), .seg(seg_ca), .dp(dp_ca), .digit_sel(sel_ca)
    );

    // ctl = {en, up_dn, clear, load}; flags = {tick, carry_out}
    typedef struct {
        logic [3:0] ctl;
        logic [7:0] lv;
        logic [7:0] exp_count;
        logic [1:0] exp_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] ctl, input logic [7:0] lv,
                                input logic [7:0] cnt, input logic [1:0] fl);
        vec_t v;
        v.ctl       = ctl;
        v.lv        = lv;
        v.exp_count = cnt;
        v.exp_flags = fl;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [7:0] lv);
        en         = ctl[3];
        up_dn      = ctl[2];
        clear      = ctl[1];
        load       = ctl[0];
        load_value = lv;
    endtask

    initial begin
        // Counting / load / clear vectors, one clock edge each
        add(4'b1100, 8'h00, 8'h00, 2'b00);
        add(4'b1100, 8'h00, 8'h00, 2'b00);
        add(4'b1100, 8'h00, 8'h00, 2'b00);
        add(4'b1100, 8'h00, 8'h01, 2'b10);   // first step after 4th edge
        add(4'b1100, 8'h00, 8'h01, 2'b00);
        add(4'b1100, 8'h00, 8'h01, 2'b00);
        add(4'b1100, 8'h00, 8'h01, 2'b00);
        add(4'b1100, 8'h00, 8'h02, 2'b10);
        add(4'b1101, 8'h99, 8'h99, 2'b00);   // load 99
        add(4'b1100, 8'h00, 8'h99, 2'b00);
        add(4'b1100, 8'h00, 8'h99, 2'b00);
        add(4'b1100, 8'h00, 8'h99, 2'b00);
        add(4'b1100, 8'h00, 8'h00, 2'b11);   // 99 -> 00 wraps
        add(4'b1000, 8'h00, 8'h00, 2'b00);
        add(4'b1000, 8'h00, 8'h00, 2'b00);
        add(4'b1000, 8'h00, 8'h00, 2'b00);
        add(4'b1000, 8'h00, 8'h99, 2'b11);   // 00 -> 99 wraps
        add(4'b1001, 8'hA3, 8'h93, 2'b00);   // saturating load
        add(4'b1000, 8'h00, 8'h93, 2'b00);
        add(4'b1000, 8'h00, 8'h93, 2'b00);
        add(4'b1000, 8'h00, 8'h93, 2'b00);
        add(4'b1000, 8'h00, 8'h92, 2'b10);   // plain decrement, no carry
        add(4'b1001, 8'h10, 8'h10, 2'b00);
        add(4'b1000, 8'h00, 8'h10, 2'b00);
        add(4'b1000, 8'h00, 8'h10, 2'b00);
        add(4'b1000, 8'h00, 8'h10, 2'b00);
        add(4'b1000, 8'h00, 8'h09, 2'b10);   // borrow ripple
        add(4'b1100, 8'h00, 8'h09, 2'b00);
        add(4'b1100, 8'h00, 8'h09, 2'b00);   // prescaler at 2
        add(4'b0100, 8'h00, 8'h09, 2'b00);   // paused: hold
        add(4'b0100, 8'h00, 8'h09, 2'b00);
        add(4'b0100, 8'h00, 8'h09, 2'b00);
        add(4'b1100, 8'h00, 8'h09, 2'b00);   // prescaler resumes at 3
        add(4'b1100, 8'h00, 8'h10, 2'b10);   // carry ripple 09 -> 10
        add(4'b0011, 8'h42, 8'h00, 2'b00);   // clear beats load
        add(4'b0001, 8'h42, 8'h42, 2'b00);
        add(4'b1100, 8'h00, 8'h42, 2'b00);
        add(4'b1100, 8'h00, 8'h42, 2'b00);
        add(4'b1100, 8'h00, 8'h42, 2'b00);
        add(4'b1100, 8'h00, 8'h43, 2'b10);
        add(4'b1100, 8'h00, 8'h43, 2'b00);
        add(4'b1100, 8'h00, 8'h43, 2'b00);
        add(4'b1110, 8'h00, 8'h00, 2'b00);   // clear mid-period
        add(4'b1000, 8'h00, 8'h00, 2'b00);
        add(4'b1000, 8'h00, 8'h00, 2'b00);
        add(4'b1000, 8'h00, 8'h00, 2'b00);
        add(4'b1100, 8'h00, 8'h01, 2'b10);   // up_dn only matters on step edge

        // Reset with en=1 held
        rst_n = 1'b0;
        drive(4'b1100, 8'h00);
        step_edge();
        rst_n = 1'b1;
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_carry", 32'(carry_out), 32'h0);
        chk("rst_seg", 32'(seg), 32'h3F);
        chk("rst_sel", 32'(digit_sel), 32'h1);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_ca_seg", 32'(seg_ca), 32'h40);
        chk("rst_ca_sel", 32'(sel_ca), 32'h2);
        chk("rst_ca_dp", 32'(dp_ca), 32'h1);

        foreach (vecs[i]) begin
            drive(vecs[i].ctl, vecs[i].lv);
            step_edge();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_flags[1]));
            chk($sformatf("vec%0d_carry", i), 32'(carry_out), 32'(vecs[i].exp_flags[0]));
            $display("vec %0d ctl=%b lv=%h count=%h tick=%b carry=%b", i,
                     vecs[i].ctl, vecs[i].lv, count, tick, carry_out);
        end

        // Scan and blanking: reset so the scan phase is known
        rst_n = 1'b0;
        drive(4'b0000, 8'h00);
        step_edge();
        rst_n = 1'b1;
        drive(4'b0001, 8'h05);
        step_edge();                         // scan cnt 1, idx 0
        chk("scan1_count", 32'(count), 32'h05);
        chk("scan1_seg", 32'(seg), 32'h6D);
        chk("scan1_sel", 32'(digit_sel), 32'h1);
        chk("scan1_dp", 32'(dp), 32'h1);
        drive(4'b0000, 8'h00);
        step_edge();                         // idx 1, leading zero
        chk("scan2_seg", 32'(seg), 32'h00);
        chk("scan2_sel", 32'(digit_sel), 32'h2);
        chk("scan2_dp", 32'(dp), 32'h0);
        chk("scan2_ca_seg", 32'(seg_ca), 32'h7F);
        chk("scan2_ca_sel", 32'(sel_ca), 32'h1);
        step_edge();
        chk("scan3_seg", 32'(seg), 32'h00);
        step_edge();                         // back to idx 0
        chk("scan4_seg", 32'(seg), 32'h6D);
        chk("scan4_sel", 32'(digit_sel), 32'h1);
        drive(4'b0001, 8'h50);
        step_edge();                         // idx 0, digit 0 is 0 but never blanked
        chk("scan5_seg", 32'(seg), 32'h3F);
        chk("scan5_sel", 32'(digit_sel), 32'h1);
        drive(4'b0000, 8'h00);
        step_edge();                         // idx 1 shows 5
        chk("scan6_seg", 32'(seg), 32'h6D);
        chk("scan6_sel", 32'(digit_sel), 32'h2);
        $display("scan seq done seg=%h sel=%b", seg, digit_sel);

        // Reset mid-count period
        drive(4'b1100, 8'h00);
        step_edge();
        step_edge();                         // prescaler at 2
        rst_n = 1'b0;
        step_edge();
        rst_n = 1'b1;
        chk("mrst_count", 32'(count), 32'h00);
        chk("mrst_tick", 32'(tick), 32'h0);
        chk("mrst_seg", 32'(seg), 32'h3F);
        chk("mrst_sel", 32'(digit_sel), 32'h1);
        chk("mrst_ca_count", 32'(count_ca), 32'h00);
        chk("mrst_ca_seg", 32'(seg_ca), 32'h40);
        chk("mrst_ca_sel", 32'(sel_ca), 32'h2);
        chk("mrst_ca_dp", 32'(dp_ca), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step_edge();
            chk($sformatf("post_rst%0d_count", k), 32'(count), (k == 4) ? 32'h01 : 32'h00);
            chk($sformatf("post_rst%0d_tick", k), 32'(tick), (k == 4) ? 32'h1 : 32'h0);
            $display("post reset edge %0d count=%h tick=%b", k, count, tick);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
